// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiplier/divider.
// Optional feature macro used by multdiv_seq: MULTDIV_EARLY_DIV0_EN.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam int          CNT_W      = 6;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/multdiv_addsub.sv
// Adder/subtractor shared by the Booth add/subtract step and the restoring
// division trial subtraction. Reports carry-out and signed overflow so the
// caller can recover the true (WIDTH+1)-bit result sign.
module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;
    logic             c_msb;

    // a + b, or a - b as a + ~b + 1; overflow is carry-into-MSB xor carry-out
    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = full[WIDTH-1:0];
        carry = full[WIDTH];
        c_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
        ovf   = c_msb ^ carry;
    end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiplier (radix-2 Booth) / divider (restoring on
// magnitudes), one iteration per clock, result pulse WIDTH+1 edges after accept.
// Define MULTDIV_EARLY_DIV0_EN to complete divide-by-zero one edge after accept.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;      // Booth: {hi, lo, q-1}; divide: {0, rem, quo}
    logic [WIDTH-1:0]   m_q, m_d;          // multiplicand, or divisor magnitude
    logic               qneg_q, qneg_d;
    logic               div0_q, div0_d;
    logic               dovf_q, dovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH-1:0]   as_a, as_sum;
    logic               as_sub, as_carry, as_ovf;
    logic [WIDTH:0]     prod_upper;
    logic               rem_ge;
    logic               booth_sign;
    logic [WIDTH-1:0]   booth_hi;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (as_a),
        .b     (m_q),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    // Steer the shared adder: trial subtract for divide, Booth add/sub for multiply
    always_comb begin
        if (state_q == DIV) begin
            as_a   = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
            as_sub = 1'b1;
        end else begin
            as_a   = acc_q[2*WIDTH:WIDTH+1];
            as_sub = (acc_q[1:0] == 2'b10);
        end
    end

    // Next-state, iteration datapath and completion results
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_d        = m_q;
        qneg_d     = qneg_q;
        div0_d     = div0_q;
        dovf_d     = dovf_q;
        result_d   = result_q;
        exc_d      = exc_q;
        rdy_d      = 1'b0;
        prod_upper = acc_q[2*WIDTH:WIDTH];
        // Shifted partial remainder is >= divisor if its spilled bit is set or no borrow
        rem_ge     = acc_q[2*WIDTH-1] | as_carry;
        // After an add/sub the true sign is the overflow-corrected MSB
        booth_sign = acc_q[2*WIDTH];
        booth_hi   = acc_q[2*WIDTH:WIDTH+1];
        if (acc_q[1] ^ acc_q[0]) begin
            booth_sign = as_sum[WIDTH-1] ^ as_ovf;
            booth_hi   = as_sum;
        end

        if (ctrl_MULT && !ctrl_DIV) begin
            state_d = MULT;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, data_operandB, 1'b0};
            m_d     = data_operandA;
        end else if (ctrl_DIV && !ctrl_MULT) begin
            state_d = DIV;
            cnt_d   = '0;
            acc_d   = {1'b0, {WIDTH{1'b0}}, magnitude(data_operandA)};
            m_d     = magnitude(data_operandB);
            qneg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_d  = (data_operandB == '0);
            dovf_d  = (data_operandA == INT_MIN) && (&data_operandB);
`ifdef MULTDIV_EARLY_DIV0_EN
            if (data_operandB == '0) begin
                cnt_d = CNT_W'(ITER_COUNT);
            end
`endif
        end else begin
            case (state_q)
                MULT: begin
                    if (cnt_q == CNT_W'(ITER_COUNT)) begin
                        result_d = acc_q[WIDTH:1];
                        exc_d    = !((&prod_upper) || !(|prod_upper));
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        acc_d = {booth_sign, booth_hi, acc_q[WIDTH:1]};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    if (cnt_q == CNT_W'(ITER_COUNT)) begin
                        if (div0_q) begin
                            result_d = '0;
                            exc_d    = 1'b1;
                        end else if (dovf_q) begin
                            result_d = INT_MIN;
                            exc_d    = 1'b1;
                        end else begin
                            result_d = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                            exc_d    = 1'b0;
                        end
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d = {1'b0, (rem_ge ? as_sum : as_a), acc_q[WIDTH-2:0], rem_ge};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Control and visible result registers, synchronously reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            div0_q   <= div0_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    // Iteration datapath registers; contents are meaningless outside MULT/DIV
    always_ff @(posedge clock) begin
        acc_q <= acc_d;
        m_q   <= m_d;
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: vector table plus corner-case sequences,
// expected completions queued at accept time and matched when RDY pulses.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
        int          tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;
    vec_t vecs[17];

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present strobes for one edge; n is the edge at which they were sampled
    task automatic drive(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, output int n);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        data_operandA = a;
        data_operandB = b;
        tick();
        n = edge_cnt;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic expect_done(input logic [31:0] res, input logic exc, input int due, input int tag);
        exp_t e;
        e.res = res;
        e.exc = exc;
        e.due = due;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, input int tag);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL timeout[%0d]: %0d completions outstanding, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard side: every RDY pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rdy: RDY=1 at edge %0d, required no completion", edge_cnt);
                end else begin
                    e = sb.pop_front();
                    check("result", e.tag, data_result, e.res);
                    check("exception", e.tag, {31'b0, data_exception}, {31'b0, e.exc});
                    check("rdy_edge", e.tag, edge_cnt, e.due);
                end
            end
        end
    end

    initial begin
        int n, n2, lat;
        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_1234, 32'hFFFF_8000, 32'hF6E6_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[13] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
        vecs[14] = '{1'b1, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0};
        vecs[15] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        check("reset_result", 0, data_result, 32'h0);
        check("reset_exc", 0, {31'b0, data_exception}, 32'h0);
        check("reset_rdy", 0, {31'b0, data_resultRDY}, 32'h0);
        check("reset_busy", 0, {31'b0, busy}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, n);
            lat = 33;
`ifdef MULTDIV_EARLY_DIV0_EN
            if (vecs[i].is_div && vecs[i].b == 32'h0) lat = 1;
`endif
            expect_done(vecs[i].res, vecs[i].exc, n + lat, i);
            if (i == 0) begin
                for (int k = 1; k <= 33; k++) begin
                    tick();
                    check("busy_window", k, {31'b0, busy}, (k <= 32) ? 32'h1 : 32'h0);
                end
            end
            wait_done(45, i);
        end

        // Restart: a DIV 10 edges into a MULT replaces it; both strobes together do nothing
        tick();
        drive(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005, n);
        repeat (9) tick();
        drive(1'b0, 1'b1, 32'd100, 32'd7, n2);
        check("restart_edge", 100, n2 - n, 32'd10);
        expect_done(32'd14, 1'b0, n + 43, 100);
        repeat (9) tick();
        drive(1'b1, 1'b1, 32'h0000_0002, 32'h0000_0002, n2);
        wait_done(40, 100);
        repeat (5) tick();

        // Reset during an in-flight MULT clears outputs and suppresses completion
        drive(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0006, n);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("abort_edge", 101, edge_cnt - n, 32'd5);
        check("abort_result", 101, data_result, 32'h0);
        check("abort_exc", 101, {31'b0, data_exception}, 32'h0);
        check("abort_rdy", 101, {31'b0, data_resultRDY}, 32'h0);
        check("abort_busy", 101, {31'b0, busy}, 32'h0);
        reset = 1'b0;
        while (edge_cnt < n + 40) tick();
        check("abort_busy_late", 101, {31'b0, busy}, 32'h0);

        // Divide-by-zero latency, stated directly for the active configuration
        drive(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, n);
`ifdef MULTDIV_EARLY_DIV0_EN
        expect_done(32'h0, 1'b1, n + 1, 102);
`else
        expect_done(32'h0, 1'b1, n + 33, 102);
`endif
        wait_done(45, 102);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
